// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: synthetic OV7670 VGA YUV422 source (vsync/href/byte stream) with test patterns
module ov7670_pattern_gen #(
  parameter int ACTIVE_PIX   = 640,
  parameter int BLANK_BYTES  = 288,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int ACTIVE_LINES = 480,
  parameter int VFP_LINES    = 10
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);
  localparam int LINE_TOTAL  = 2 * ACTIVE_PIX + BLANK_BYTES;
  localparam int FRAME_LINES = VSYNC_LINES + VBP_LINES + ACTIVE_LINES + VFP_LINES;
  localparam int ACT_START   = VSYNC_LINES + VBP_LINES;
  localparam int BW          = $clog2(LINE_TOTAL);
  localparam int LW          = $clog2(FRAME_LINES);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t          state, nxt_state;
  logic [BW-1:0]   byte_cnt, nxt_byte;
  logic [LW-1:0]   line_cnt, nxt_line;
  logic [1:0]      sel, nxt_sel;
  logic            last_byte, eof, restart, n_href;
  logic [7:0]      x, y, luma;

  // Outputs are computed from the next position so the registered strobes line up with the counters.
  always_comb begin
    last_byte = byte_cnt == BW'(LINE_TOTAL - 1);
    eof       = state == VFP && last_byte && line_cnt == LW'(FRAME_LINES - 1);
    restart   = state == IDLE || eof;
    nxt_byte  = (restart || last_byte) ? '0 : byte_cnt + BW'(1);
    nxt_line  = restart ? '0 : line_cnt + LW'(last_byte);
    nxt_sel   = (restart && enable) ? pattern_sel : sel;
    nxt_state = state;
    case (state)
      IDLE:    nxt_state = enable ? VSYNC : IDLE;
      VSYNC:   if (last_byte && line_cnt == LW'(VSYNC_LINES - 1)) nxt_state = VBP;
      VBP:     if (last_byte && line_cnt == LW'(ACT_START - 1)) nxt_state = ACTIVE;
      ACTIVE:  if (last_byte && line_cnt == LW'(ACT_START + ACTIVE_LINES - 1)) nxt_state = VFP;
      VFP:     if (eof) nxt_state = enable ? VSYNC : IDLE;
      default: nxt_state = IDLE;
    endcase
    x      = 8'(nxt_byte >> 1);
    y      = 8'(nxt_line - LW'(ACT_START));
    luma   = nxt_sel == 2'd0 ? x :
             nxt_sel == 2'd1 ? y :
             nxt_sel == 2'd2 ? {8{x[3] ^ y[3]}} : frame_cnt;
    n_href = nxt_state == ACTIVE && nxt_byte < BW'(2 * ACTIVE_PIX);
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      sel        <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      cam_data   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= nxt_state;
      byte_cnt   <= nxt_byte;
      line_cnt   <= nxt_line;
      sel        <= nxt_sel;
      vsync      <= nxt_state == VSYNC;
      href       <= n_href;
      cam_data   <= n_href ? (nxt_byte[0] ? 8'h80 : luma) : 8'h00;
      frame_done <= nxt_state == VFP && nxt_byte == BW'(LINE_TOTAL - 1) &&
                    nxt_line == LW'(FRAME_LINES - 1);
      frame_cnt  <= frame_cnt + 8'(eof);
    end
  end
endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// tb_ov7670_pattern_gen: random-phase stimulus against a frame-position model of the pattern generator
module tb_ov7670_pattern_gen;
  localparam int AP = 16, BB = 4, VS = 1, VB = 1, AL = 2, VF = 1;
  localparam int LT = 2 * AP + BB;
  localparam int FT = (VS + VB + AL + VF) * LT;

  logic       clk25 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic       vsync, href, frame_done;
  logic [7:0] cam_data, frame_cnt;

  int n_chk = 0, n_fail = 0;

  ov7670_pattern_gen #(.ACTIVE_PIX(AP), .BLANK_BYTES(BB), .VSYNC_LINES(VS), .VBP_LINES(VB),
                       .ACTIVE_LINES(AL), .VFP_LINES(VF)) dut (
    .clk25(clk25), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .vsync(vsync), .href(href), .cam_data(cam_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a running frame is just a position 0..FT-1; everything else is arithmetic on it.
  bit m_run = 0;
  int m_pos = 0, m_cnt = 0, m_sel = 0;
  always @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 0; m_pos <= 0; m_cnt <= 0; m_sel <= 0;
    end else if (!m_run) begin
      if (enable) begin m_run <= 1; m_pos <= 0; m_sel <= pattern_sel; end
    end else if (m_pos == FT - 1) begin
      m_cnt <= (m_cnt + 1) % 256;
      m_pos <= 0;
      m_run <= enable;
      if (enable) m_sel <= pattern_sel;
    end else m_pos <= m_pos + 1;
  end

  always @(negedge clk25) begin : cmp
    int line, b, x, y, luma, e_data;
    bit e_hr;
    line = m_pos / LT;
    b    = m_pos % LT;
    x    = b / 2;
    y    = line - VS - VB;
    e_hr = m_run && line >= VS + VB && line < VS + VB + AL && b < 2 * AP;
    luma = m_sel == 0 ? x % 256 : m_sel == 1 ? y % 256 :
           m_sel == 2 ? (((x / 8) % 2 != (y / 8) % 2) ? 255 : 0) : m_cnt;
    e_data = e_hr ? (b % 2 == 1 ? 128 : luma) : 0;
    chk("vsync", int'(vsync), int'(m_run && line < VS));
    chk("href", int'(href), int'(e_hr));
    chk("cam_data", int'(cam_data), e_data);
    chk("frame_done", int'(frame_done), int'(m_run && m_pos == FT - 1));
    chk("frame_cnt", int'(frame_cnt), m_cnt);
  end

  int cyc = 0, hcur = 0, vcur = 0;
  logic hprev = 0, vprev = 0;
  int rises[$], hw[$], vw[$], vr[$], dones[$], bytes[$];
  always @(negedge clk25) begin
    cyc   <= cyc + 1;
    hprev <= href;
    vprev <= vsync;
    hcur  <= href ? hcur + 1 : 0;
    vcur  <= vsync ? vcur + 1 : 0;
    if (href && !hprev) rises.push_back(cyc);
    if (!href && hprev) hw.push_back(hcur);
    if (vsync && !vprev) vr.push_back(cyc);
    if (!vsync && vprev) vw.push_back(vcur);
    if (frame_done) dones.push_back(cyc);
    if (href) bytes.push_back(int'(cam_data));
  end

  task automatic wait_done(input string nm);
    bit got = 0;
    for (int i = 0; i < 2 * FT && !got; i++) begin
      @(negedge clk25);
      if (frame_done) got = 1;
    end
    chk(nm, int'(got), 1);
    #1;
  endtask

  task automatic wait_href();
    bit got = 0;
    for (int i = 0; i < 2 * FT && !got; i++) begin
      @(negedge clk25);
      if (href) got = 1;
    end
    chk("href_seen", int'(got), 1);
  endtask

  task automatic clear_line_stats();
    rises.delete(); hw.delete(); vw.delete(); bytes.delete();
  endtask

  initial begin
    int ramp[8] = '{0, 128, 1, 128, 2, 128, 3, 128};
    repeat (5) @(negedge clk25);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_href", int'(href), 0);
    chk("rst_data", int'(cam_data), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    clear_line_stats();
    reset_n = 1'b1;
    @(negedge clk25);
    chk("vsync_first", int'(vsync), 1);
    repeat ($urandom_range(40, 60)) @(negedge clk25);
    pattern_sel = 2'd2;
    wait_done("done_f1");
    chk("vsync_width", vw.size() > 0 ? vw[0] : -1, LT);
    chk("href_pulses", rises.size(), AL);
    chk("href_w0", hw.size() > 0 ? hw[0] : -1, 2 * AP);
    chk("href_w1", hw.size() > 1 ? hw[1] : -1, 2 * AP);
    chk("href_spacing", rises.size() > 1 ? rises[1] - rises[0] : -1, LT);
    chk("bytes_f1", bytes.size(), 2 * AL * AP);
    for (int i = 0; i < 8; i++) chk("ramp_l0", bytes.size() > i ? bytes[i] : -1, ramp[i]);
    chk("ramp_l1_x1", bytes.size() > 2 * AP + 2 ? bytes[2 * AP + 2] : -1, 1);
    clear_line_stats();
    repeat ($urandom_range(40, 60)) @(negedge clk25);
    pattern_sel = 2'd3;
    wait_done("done_f2");
    chk("chk_x7", bytes.size() > 14 ? bytes[14] : -1, 8'h00);
    chk("chk_x8", bytes.size() > 16 ? bytes[16] : -1, 8'hFF);
    chk("chk_x15", bytes.size() > 30 ? bytes[30] : -1, 8'hFF);
    chk("chk_u", bytes.size() > 1 ? bytes[1] : -1, 8'h80);
    chk("chk_l1_x8", bytes.size() > 2 * AP + 16 ? bytes[2 * AP + 16] : -1, 8'hFF);
    clear_line_stats();
    wait_done("done_f3");
    chk("flat_l0", bytes.size() > 0 ? bytes[0] : -1, 2);
    chk("flat_l1", bytes.size() > 2 * AP ? bytes[2 * AP] : -1, 2);
    repeat (20) @(negedge clk25);
    enable = 1'b0;
    chk("cnt_after3", int'(frame_cnt), 3);
    chk("done_gap1", dones.size() > 1 ? dones[1] - dones[0] : -1, FT);
    chk("done_gap2", dones.size() > 2 ? dones[2] - dones[1] : -1, FT);
    chk("vs_rerise1", vr.size() > 1 && dones.size() > 0 ? vr[1] - dones[0] : -1, 1);
    chk("vs_rerise2", vr.size() > 2 && dones.size() > 1 ? vr[2] - dones[1] : -1, 1);
    wait_done("done_f4");
    repeat ($urandom_range(10, 30)) @(negedge clk25);
    chk("idle_vsync", int'(vsync), 0);
    chk("idle_href", int'(href), 0);
    chk("idle_cnt", int'(frame_cnt), 4);
    chk("no_restart", vr.size(), 4);
    pattern_sel = 2'd1;
    enable = 1'b1;
    wait_href();
    #3 reset_n = 1'b0;
    #1;
    chk("async_href", int'(href), 0);
    chk("async_data", int'(cam_data), 0);
    chk("async_cnt", int'(frame_cnt), 0);
    repeat (3) @(negedge clk25);
    clear_line_stats();
    reset_n = 1'b1;
    wait_done("done_f6");
    chk("vramp_l0", bytes.size() > 2 ? bytes[2] : -1, 0);
    chk("vramp_l1", bytes.size() > 2 * AP + 2 ? bytes[2 * AP + 2] : -1, 1);
    enable = 1'b0;
    @(negedge clk25);
    chk("cnt_restart", int'(frame_cnt), 1);
    repeat (5) @(negedge clk25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
